// File: rtl/spi_clk_arbiter.sv
// Round-robin owner of the shared SCLK divider: grants one SPI requester at a time,
// configures the divider, runs one start/ready handshake per byte, then releases.
// Optional watchdog abort on a stuck divider is compiled in with SPI_ARB_WDOG_EN.
module spi_clk_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*8-1:0]       i_divisor,
    input  logic [N_REQ*CNT_W-1:0]   i_nbytes,
    output logic [N_REQ-1:0]         o_grant,
    output logic [N_REQ-1:0]         o_cs_n,
    output logic [N_REQ-1:0]         o_done,
    output logic                     o_busy,
    output logic [8:0]               o_div_config,
    output logic                     o_div_start_n,
    input  logic                     i_div_ready,
    output logic                     o_byte_tick
`ifdef SPI_ARB_WDOG_EN
    ,
    output logic                     o_timeout
`endif
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CONFIG, S_CS_SETUP, S_START, S_WAIT_DONE, S_CS_HOLD, S_DONE
    } state_t;

    state_t           state;
    logic [PW-1:0]    ptr, w, sel, w_next;
    logic [7:0]       div, sel_div;
    logic [CNT_W-1:0] rem, sel_cnt;

    // Search downwards so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        sel = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[PW'((int'(ptr) + i) % N_REQ)])
                sel = PW'((int'(ptr) + i) % N_REQ);
        end
    end

    assign sel_div = (i_divisor[8*int'(sel) +: 8] < 8'd2) ? 8'd2 : i_divisor[8*int'(sel) +: 8];
    assign sel_cnt = i_nbytes[CNT_W*int'(sel) +: CNT_W];
    assign w_next  = (w == PW'(N_REQ - 1)) ? '0 : w + 1'b1;

`ifdef SPI_ARB_WDOG_EN
    logic [15:0] wdog, wd_limit;
    assign wd_limit = {5'd0, div, 3'd0} + 16'd32;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= S_IDLE;
            ptr           <= '0;
            w             <= '0;
            div           <= '0;
            rem           <= '0;
            o_grant       <= '0;
            o_cs_n        <= '1;
            o_done        <= '0;
            o_busy        <= 1'b0;
            o_div_config  <= '0;
            o_div_start_n <= 1'b1;
            o_byte_tick   <= 1'b0;
`ifdef SPI_ARB_WDOG_EN
            wdog          <= '0;
            o_timeout     <= 1'b0;
`endif
        end else begin
            o_done      <= '0;
            o_byte_tick <= 1'b0;
`ifdef SPI_ARB_WDOG_EN
            o_timeout   <= 1'b0;
`endif
            case (state)
                S_IDLE: if (|i_req) begin
                    w            <= sel;
                    div          <= sel_div;
                    rem          <= sel_cnt;
                    o_grant[sel] <= 1'b1;
                    o_busy       <= 1'b1;
                    if (sel_cnt == '0) begin
                        state <= S_DONE;
                    end else begin
                        state        <= S_CONFIG;
                        o_div_config <= {sel_div, 1'b1};
                    end
                end
                S_CONFIG: begin
                    o_div_config <= '0;
                    o_cs_n[w]    <= 1'b0;
                    state        <= S_CS_SETUP;
                end
                S_CS_SETUP: begin
                    o_div_start_n <= 1'b0;
                    state         <= S_START;
`ifdef SPI_ARB_WDOG_EN
                    wdog          <= '0;
`endif
                end
                S_START: begin
`ifdef SPI_ARB_WDOG_EN
                    wdog <= wdog + 16'd1;
`endif
                    if (!i_div_ready) begin
                        o_div_start_n <= 1'b1;
                        state         <= S_WAIT_DONE;
                    end
`ifdef SPI_ARB_WDOG_EN
                    else if (wdog == 16'd7) begin
                        o_div_start_n <= 1'b1;
                        o_cs_n        <= '1;
                        o_grant       <= '0;
                        o_done[w]     <= 1'b1;
                        o_timeout     <= 1'b1;
                        o_busy        <= 1'b0;
                        ptr           <= w_next;
                        state         <= S_IDLE;
                    end
`endif
                end
                S_WAIT_DONE: begin
`ifdef SPI_ARB_WDOG_EN
                    wdog <= wdog + 16'd1;
`endif
                    if (i_div_ready) begin
                        o_byte_tick <= 1'b1;
                        rem         <= rem - 1'b1;
                        if (rem == CNT_W'(1)) begin
                            state <= S_CS_HOLD;
                        end else begin
                            o_div_start_n <= 1'b0;
                            state         <= S_START;
`ifdef SPI_ARB_WDOG_EN
                            wdog          <= '0;
`endif
                        end
                    end
`ifdef SPI_ARB_WDOG_EN
                    else if (wdog > wd_limit) begin
                        o_cs_n    <= '1;
                        o_grant   <= '0;
                        o_done[w] <= 1'b1;
                        o_timeout <= 1'b1;
                        o_busy    <= 1'b0;
                        ptr       <= w_next;
                        state     <= S_IDLE;
                    end
`endif
                end
                S_CS_HOLD: state <= S_DONE;
                S_DONE: begin
                    o_cs_n    <= '1;
                    o_done[w] <= 1'b1;
                    o_grant   <= '0;
                    o_busy    <= 1'b0;
                    ptr       <= w_next;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_clk_arbiter.sv
// Directed bench for spi_clk_arbiter with a behavioural SCLK divider model.
module tb_spi_clk_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] divisor, nbytes;
    logic [3:0]  grant, cs_n, done;
    logic        busy, start_n, tick;
    logic [8:0]  div_config;
    logic        ready = 1'b1;
`ifdef SPI_ARB_WDOG_EN
    logic        to;
`endif

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    spi_clk_arbiter #(.N_REQ(4), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_divisor(divisor), .i_nbytes(nbytes),
        .o_grant(grant), .o_cs_n(cs_n), .o_done(done), .o_busy(busy),
        .o_div_config(div_config), .o_div_start_n(start_n), .i_div_ready(ready),
        .o_byte_tick(tick)
`ifdef SPI_ARB_WDOG_EN
        , .o_timeout(to)
`endif
    );

    // Divider model: ready drops on a sampled start and stays low 8*div cycles.
    logic       run = 1'b0, stuck = 1'b0;
    logic [7:0] mdiv = 8'd2;
    int         mcnt = 0;
    always @(posedge clk) begin
        if (div_config[0]) mdiv <= div_config[8:1];
        if (stuck) begin
            ready <= 1'b1; run <= 1'b0;
        end else if (run) begin
            if (mcnt == 0) begin ready <= 1'b1; run <= 1'b0; end
            else mcnt <= mcnt - 1;
        end else if (!start_n) begin
            run <= 1'b1; ready <= 1'b0; mcnt <= 8 * int'(mdiv) - 1;
        end
    end

    int         n_cfg = 0, n_tick = 0, n_start = 0, n_cslow = 0;
    int         n_multi_cs = 0, n_multi_gnt = 0, n_tick_cs_hi = 0;
    logic [8:0] last_cfg = '0;
    logic       prev_sn = 1'b1;
    logic [3:0] prev_g = '0;
    int         gq[$];
    always @(negedge clk) begin
        if (div_config != 0) begin n_cfg++; last_cfg = div_config; end
        if (tick) begin n_tick++; if (cs_n == 4'hF) n_tick_cs_hi++; end
        if (prev_sn && !start_n) n_start++;
        prev_sn = start_n;
        if (cs_n != 4'hF) n_cslow++;
        if ($countones(~cs_n) > 1) n_multi_cs++;
        if ($countones(grant) > 1) n_multi_gnt++;
        if (grant != prev_g && grant != 0) gq.push_back($clog2(grant));
        prev_g = grant;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic wait_done(input int lim, output logic [3:0] d, output int cyc);
        d = '0; cyc = 0;
        while (cyc < lim && d == 0) begin step(); cyc++; d = done; end
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0; step();
    endtask

    logic [3:0] d;
    int cyc, c0, c1, c2, c3, c4, nd;

    initial begin
        req = '0; divisor = {8'd2, 8'd2, 8'd2, 8'd2}; nbytes = {8'd1, 8'd1, 8'd1, 8'd1};
        rst = 1'b1; step();
        chk("rst_grant", grant, 0);
        chk("rst_cs_n", cs_n, 4'hF);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg", div_config, 0);
        chk("rst_start_n", start_n, 1);
        chk("rst_tick", tick, 0);
        rst = 1'b0; step();

        // Single request: divisor 4, three bytes
        divisor[15:8] = 8'd4; nbytes[15:8] = 8'd3;
        c0 = n_cfg; c1 = n_tick; c2 = n_start; c3 = n_tick_cs_hi;
        req = 4'b0010; step(); req = '0;
        chk("single_grant", grant, 4'b0010);
        chk("single_busy", busy, 1);
        wait_done(1000, d, cyc);
        chk("single_done", d, 4'b0010);
        chk("single_cfg_cycles", n_cfg - c0, 1);
        chk("single_cfg_val", last_cfg, 9'h009);
        chk("single_ticks", n_tick - c1, 3);
        chk("single_starts", n_start - c2, 3);
        chk("single_cs_held", n_tick_cs_hi - c3, 0);
        chk("single_latency", ((cyc + 1) >= 96 && (cyc + 1) <= 140), 1);
        step();
        chk("single_idle_grant", grant, 0);

        // Round robin from pointer 0
        do_reset();
        divisor = {8'd2, 8'd2, 8'd2, 8'd2}; nbytes = {8'd1, 8'd1, 8'd1, 8'd1};
        gq.delete(); c0 = n_multi_cs; c1 = n_multi_gnt; nd = 0;
        req = 4'hF;
        for (int i = 0; i < 2000 && nd < 5; i++) begin
            step();
            if (done != 0) nd++;
        end
        req = '0;
        chk("rr_dones", nd, 5);
        chk("rr_grants", gq.size(), 5);
        for (int i = 0; i < 5 && i < gq.size(); i++) chk($sformatf("rr_order%0d", i), gq[i], i % 4);
        chk("rr_multi_cs", n_multi_cs - c0, 0);
        chk("rr_multi_grant", n_multi_gnt - c1, 0);
        step();

        // Zero byte count on requester 2
        nbytes[23:16] = 8'd0; c0 = n_cfg; c1 = n_cslow;
        req = 4'b0100;
        wait_done(20, d, cyc); req = '0;
        chk("zero_done", d, 4'b0100);
        chk("zero_latency", cyc, 2);
        chk("zero_no_cfg", n_cfg - c0, 0);
        chk("zero_no_cs", n_cslow - c1, 0);
        step();

        // Divisor 1 clamps to 2
        divisor[7:0] = 8'd1; nbytes[7:0] = 8'd1;
        req = 4'b0001; step(); req = '0;
        wait_done(500, d, cyc);
        chk("clamp_done", d, 4'b0001);
        chk("clamp_cfg", last_cfg, 9'h005);
        step();

        // Request dropped mid-transfer
        nbytes[7:0] = 8'd2; c0 = n_tick;
        req = 4'b0001; step();
        repeat (10) step();
        req = '0;
        wait_done(500, d, cyc);
        chk("drop_done", d, 4'b0001);
        chk("drop_ticks", n_tick - c0, 2);
        step();

        // Reset while the divider is running a byte
        divisor[15:8] = 8'd4; nbytes[15:8] = 8'd3;
        req = 4'b0010; step(); req = '0;
        repeat (12) step();
        chk("midrst_pre_busy", busy, 1);
        chk("midrst_pre_cs", cs_n, 4'b1101);
        rst = 1'b1; #1;
        chk("midrst_cs_n", cs_n, 4'hF);
        chk("midrst_grant", grant, 0);
        chk("midrst_start_n", start_n, 1);
        chk("midrst_busy", busy, 0);
        step(); rst = 1'b0;
        for (int i = 0; i < 200 && !ready; i++) step();
        step();

`ifdef SPI_ARB_WDOG_EN
        begin
            int ts, tt;
            logic [3:0] td, tcs, nxt;
            do_reset();
            stuck = 1'b1; nbytes = {8'd1, 8'd1, 8'd1, 8'd1};
            ts = -1; tt = -1; td = '0; tcs = '0; nxt = '0;
            req = 4'b0011;
            for (int i = 0; i < 100; i++) begin
                step();
                if (ts < 0 && !start_n) ts = i;
                if (tt < 0 && to) begin
                    tt = i; td = done; tcs = cs_n;
                end else if (tt >= 0 && grant != 0) begin
                    nxt = grant; break;
                end
            end
            req = '0;
            chk("wdog_seen", (tt >= 0 && ts >= 0), 1);
            chk("wdog_delay", tt - ts, 8);
            chk("wdog_done", td, 4'b0001);
            chk("wdog_cs", tcs, 4'hF);
            chk("wdog_next", nxt, 4'b0010);
            repeat (30) step();
            stuck = 1'b0;
            step();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_clk_arbiter.md
Name: spi_clk_arbiter

Overview:
- Round-robin scheduler that shares a single clock_divider (SCLK generator) between N_REQ SPI requesters.
- For each granted request it:
  - loads the requester's divisor into the divider;
  - asserts that requester's chip select;
  - issues one divider start per byte and counts completions;
  - releases the bus with a done pulse.
- Sits between per-device front ends and the clock_divider / shift datapath in the SPI controller.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- CNT_W, 8, width of per-request byte count

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_req  in  N_REQ  level request per requester; sampled only in IDLE
- i_divisor  in  N_REQ*8  per-requester SCLK divisor; slice k = [8k+7:8k]
- i_nbytes  in  N_REQ*CNT_W  per-requester byte count
- o_grant  out  N_REQ  one-hot grant; zero when idle
- o_cs_n  out  N_REQ  active-low chip selects
- o_done  out  N_REQ  1-cycle pulse when requester's transfer completes
- o_busy  out  1  high in every state except IDLE
- o_div_config  out  9  {divisor[7:0], load}, to the divider config input
- o_div_start_n  out  1  active-low start, to the divider
- i_div_ready  in  1  divider ready; low while 8 SCLK periods run
- o_byte_tick  out  1  1-cycle pulse per completed byte (datapath load/unload strobe)

Behaviour:
- Reset values (async, immediate): o_grant=0, o_cs_n=all 1, o_done=0, o_busy=0, o_div_config=0, o_div_start_n=1, o_byte_tick=0; RR pointer=0; state IDLE.
- Reset mid-transfer: outputs revert immediately as above. The divider is not reset by this block.
- All outputs are registered.
- IDLE:
  - If i_req != 0, pick the first set bit searching from ptr, ptr+1, ... mod N_REQ.
  - Latch winner index, divisor and nbytes.
  - o_grant[w]=1 next cycle.
  - If latched nbytes==0, go to DONE; otherwise go to CONFIG.
- Divisor clamp: latched divisor < 2 is clamped to 2.
- CONFIG (1 cycle): o_div_config={div,1'b1}; next state CS_SETUP. o_div_config returns to 0 on exit.
- CS_SETUP (1 cycle): o_cs_n[w]=0; next state START.
- START:
  - o_div_start_n=0, held until i_div_ready is sampled 0.
  - Then o_div_start_n=1 and go to WAIT_DONE.
- WAIT_DONE: on i_div_ready sampled 1:
  - o_byte_tick pulse and remaining--.
  - If remaining==0, go to CS_HOLD; otherwise go to START.
- CS_HOLD (1 cycle): cs still low; next state DONE.
- DONE (1 cycle):
  - o_cs_n[w]=1, o_done[w]=1, o_grant cleared.
  - ptr = w+1 mod N_REQ.
  - Next state IDLE.
- Requests:
  - Changes to i_req, i_divisor or i_nbytes after latch are ignored until IDLE.
  - A requester still asserting i_req after its done competes normally; RR guarantees the others go first.
- Min idle gap between grants: 1 cycle (IDLE).
- Per-byte latency: START→WAIT_DONE handshake plus ≈8*div cycles of divider run.

Optional Feature:
- Macro SPI_ARB_WDOG_EN.
- Enabled:
  - Adds o_timeout (out, 1, reset 0) and a 16-bit watchdog counter, cleared on entering START.
  - In START: if i_div_ready is not low within 8 cycles, abort.
  - In WAIT_DONE: if the count exceeds 8*div+32, abort.
  - Abort sequence: o_div_start_n=1, cs released, o_timeout 1-cycle pulse alongside o_done[w], ptr advances, state IDLE.
- Disabled: no counter, no o_timeout port; the block waits indefinitely.

Test Plan:
- Reset: assert i_rst mid-WAIT_DONE → same cycle o_cs_n=4'b1111, o_grant=0, o_div_start_n=1, o_busy=0.
- Single request: i_req=4'b0010, divisor=4, nbytes=3, behavioural divider →
  - o_div_config=0x009 for exactly 1 cycle;
  - o_cs_n[1] low throughout;
  - 3 start handshakes, 3 o_byte_tick pulses;
  - o_done[1] pulse after ≈96+overhead cycles.
- Round-robin: i_req=4'b1111 held, nbytes=1 each → grants in order 0,1,2,3,0; no grant overlap; o_cs_n never has two zeros.
- Zero count / clamp:
  - nbytes=0 on req 2 → o_done[2] two cycles after request; no cs assertion, no config write.
  - divisor=1 → o_div_config=0x005.
- Request drop: deassert i_req[0] mid-transfer of nbytes=2 → both bytes still complete and o_done[0] pulses.
- Watchdog (SPI_ARB_WDOG_EN): divider ready stuck high → o_timeout and o_done[w] 8 cycles after start; cs released; next requester granted.
